id_operand_unit: RTL and testbench
==================================

# id_operand_unit

Parametrised decode-stage operand unit: the next-generation successor of the ID-stage hazard/bypass logic, sitting between the IF/ID pipeline boundary and EX. It holds one instruction in a valid/allow-in pipeline register, fetches NRD source operands from the register file, and resolves each one through NFWD prioritised forwarding ports. It stalls on a per-register latency scoreboard, so any multi-cycle producer is covered, not just loads. Flush cancels the held instruction.

## Interface
- XLEN, 32, datapath width
- REG_AW, 5, register address width (2^REG_AW registers)
- NRD, 2, source operand ports
- NFWD, 3, forwarding ports; index 0 = youngest, highest priority
- PAY_W, 64, opaque payload width (pc, pc4, control fields)
- LAT_W, 2, scoreboard counter width (max latency 2^LAT_W-1)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  IF has an instruction
- in_allow  out  1  unit accepts this cycle
- in_payload  in  PAY_W  passed through unchanged
- in_rs_en  in  NRD  source i used
- in_rs_addr  in  NRD*REG_AW  source addresses, port i at [i*REG_AW +: REG_AW]
- in_rd_we, in_rd_addr  in  1, REG_AW  destination
- in_lat  in  LAT_W  cycles after issue before the result appears on any forwarding port (0 = available next cycle)
- flush  in  1  cancel held instruction
- rf_raddr  out  NRD*REG_AW  = held rs addresses
- rf_rdata  in  NRD*XLEN  combinational RF read data
- fwd_valid, fwd_we  in  NFWD each
- fwd_addr  in  NFWD*REG_AW
- fwd_data  in  NFWD*XLEN
- out_valid  out  1  to EX
- out_allow  in  1  EX accepts
- out_payload, out_rs_data, out_rd_we, out_rd_addr  out  held fields; out_rs_data is NRD*XLEN resolved operands
- stall_cnt  out  32  stall-cycle counter (see Configuration)

## Operation
- Held register: valid, payload, rs_en, rs_addr, rd_we, rd_addr, lat.
- Capture when in_allow & in_valid & !flush. valid <= in_valid when in_allow; flush forces valid <= 0 with priority.
- Operand i: lowest index j with fwd_valid[j] & fwd_we[j] & fwd_addr[j]==rs_addr[i] & rs_addr[i]!=0 supplies fwd_data[j]; otherwise rf_rdata[i]. Address 0 always yields 0.
- Scoreboard: one LAT_W counter per register 1..2^REG_AW-1; register 0 is never busy.
- stall = valid & OR over i of (rs_en[i] & busy[rs_addr[i]]!=0).
- ready_go = !stall. out_valid = valid & ready_go & !flush. in_allow = !valid | (ready_go & out_allow).
- fire = out_valid & out_allow.
- Each cycle every nonzero counter decrements by 1.
- On fire with rd_we & rd_addr!=0 & lat!=0, the counter for rd_addr is set to max(counter-1, lat).
- Flush never clears the scoreboard: older producers still complete.

## Timing
- Reset: valid=0, all counters 0, stall_cnt=0, held fields 0. Hence out_valid=0, in_allow=1.
- Operand resolve, stall and handshake are combinational in the current cycle. Capture takes 1 cycle.
- Example: load issued with lat=1 at cycle t. Its counter is 1 in t+1, so a dependent held instruction stalls. In t+2 the counter is 0 and the MEM forwarding port supplies the data.
- Stall with out_allow=1: in_allow=0, held contents stable.
- flush & stall in the same cycle: valid cleared, no fire, and the stall does not count.
- Reset asserted mid-stall: all state clears immediately and asynchronously.

## Configuration
- ID_OPERAND_PERF_EN defined: stall_cnt increments each cycle that valid & stall & !flush, and saturates at 0xFFFFFFFF.
- ID_OPERAND_PERF_EN undefined: stall_cnt is constant 0 and no counter flops are built.

## Test plan
- Forward priority: hold rs0=x5, fwd0 and fwd1 both match x5 (0xAAAA / 0xBBBB) -> operand 0xAAAA. With fwd0_valid=0 -> 0xBBBB. With no match -> rf_rdata.
- x0 source: rs0=0, fwd0 matches addr 0 with data 0x1234 -> operand 0.
- Load-use: issue rd=x7 lat=1, next instruction reads x7 -> exactly 1 stall cycle (in_allow=0, out_valid=0), then fires with fwd data. stall_cnt=1 when the macro is defined.
- Latency 3: issue rd=x9 lat=3, then a dependent -> 3 stall cycles. A second issue to x9 with lat=1 while the counter is 2 -> counter stays at max(1,1)=1.
- Flush during stall: flush=1 -> out_valid=0 that cycle, valid=0 next cycle. Scoreboard keeps counting down, and a new instruction is accepted the cycle after.
- Backpressure: out_allow=0 for 4 cycles -> held fields stable, in_allow=0. Release -> fire on the first cycle out_allow=1.

Source files
------------

// File: rtl/id_operand_unit.sv
// id_operand_unit: decode-stage operand unit.
// Holds one instruction in a valid/allow-in register, resolves NRD source
// operands through NFWD prioritised forwarding ports, and stalls on a
// per-register latency scoreboard.
// Optional feature: define ID_OPERAND_PERF_EN to build the stall-cycle counter.
module id_operand_unit #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int NRD    = 2,
    parameter int NFWD   = 3,
    parameter int PAY_W  = 64,
    parameter int LAT_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_allow,
    input  logic [PAY_W-1:0]       in_payload,
    input  logic [NRD-1:0]         in_rs_en,
    input  logic [NRD*REG_AW-1:0]  in_rs_addr,
    input  logic                   in_rd_we,
    input  logic [REG_AW-1:0]      in_rd_addr,
    input  logic [LAT_W-1:0]       in_lat,
    input  logic                   flush,
    output logic [NRD*REG_AW-1:0]  rf_raddr,
    input  logic [NRD*XLEN-1:0]    rf_rdata,
    input  logic [NFWD-1:0]        fwd_valid,
    input  logic [NFWD-1:0]        fwd_we,
    input  logic [NFWD*REG_AW-1:0] fwd_addr,
    input  logic [NFWD*XLEN-1:0]   fwd_data,
    output logic                   out_valid,
    input  logic                   out_allow,
    output logic [PAY_W-1:0]       out_payload,
    output logic [NRD*XLEN-1:0]    out_rs_data,
    output logic                   out_rd_we,
    output logic [REG_AW-1:0]      out_rd_addr,
    output logic [31:0]            stall_cnt
);

    localparam int NREG = 1 << REG_AW;

    // Held instruction
    logic                  valid_q,   valid_d;
    logic [PAY_W-1:0]      payload_q, payload_d;
    logic [NRD-1:0]        rs_en_q,   rs_en_d;
    logic [NRD*REG_AW-1:0] rs_addr_q, rs_addr_d;
    logic                  rd_we_q,   rd_we_d;
    logic [REG_AW-1:0]     rd_addr_q, rd_addr_d;
    logic [LAT_W-1:0]      lat_q,     lat_d;

    // Scoreboard: remaining cycles until each register's result is forwardable
    logic [LAT_W-1:0] busy_q [NREG];
    logic [LAT_W-1:0] busy_d [NREG];

    logic [NRD*XLEN-1:0] rs_data;
    logic [NRD-1:0]      fwd_hit;
    logic                stall;
    logic                fire;

    // Operand resolve: lowest-index matching forwarding port wins, x0 reads 0
    always_comb begin
        rs_data = '0;
        fwd_hit = '0;
        stall   = 1'b0;
        for (int unsigned i = 0; i < NRD; i++) begin
            rs_data[i*XLEN +: XLEN] = rf_rdata[i*XLEN +: XLEN];
            for (int unsigned j = 0; j < NFWD; j++) begin
                if (!fwd_hit[i] && fwd_valid[j] && fwd_we[j] &&
                    (fwd_addr[j*REG_AW +: REG_AW] == rs_addr_q[i*REG_AW +: REG_AW])) begin
                    rs_data[i*XLEN +: XLEN] = fwd_data[j*XLEN +: XLEN];
                    fwd_hit[i] = 1'b1;
                end
            end
            if (rs_addr_q[i*REG_AW +: REG_AW] == '0) begin
                rs_data[i*XLEN +: XLEN] = '0;
            end
            if (valid_q && rs_en_q[i] && (busy_q[rs_addr_q[i*REG_AW +: REG_AW]] != '0)) begin
                stall = 1'b1;
            end
        end
    end

    assign out_valid   = valid_q & ~stall & ~flush;
    assign in_allow    = ~valid_q | (~stall & out_allow);
    assign fire        = out_valid & out_allow;
    assign rf_raddr    = rs_addr_q;
    assign out_payload = payload_q;
    assign out_rs_data = rs_data;
    assign out_rd_we   = rd_we_q;
    assign out_rd_addr = rd_addr_q;

    // Held-register next state: flush clears valid with priority over capture
    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        rs_en_d   = rs_en_q;
        rs_addr_d = rs_addr_q;
        rd_we_d   = rd_we_q;
        rd_addr_d = rd_addr_q;
        lat_d     = lat_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (in_allow) begin
            valid_d = in_valid;
        end
        if (in_allow && in_valid && !flush) begin
            payload_d = in_payload;
            rs_en_d   = in_rs_en;
            rs_addr_d = in_rs_addr;
            rd_we_d   = in_rd_we;
            rd_addr_d = in_rd_addr;
            lat_d     = in_lat;
        end
    end

    // Held-register state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
            rs_en_q   <= '0;
            rs_addr_q <= '0;
            rd_we_q   <= 1'b0;
            rd_addr_q <= '0;
            lat_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
            rs_en_q   <= rs_en_d;
            rs_addr_q <= rs_addr_d;
            rd_we_q   <= rd_we_d;
            rd_addr_q <= rd_addr_d;
            lat_q     <= lat_d;
        end
    end

    // Scoreboard next state: count down, issuing producer raises to max(cnt-1, lat)
    always_comb begin
        for (int unsigned r = 0; r < NREG; r++) begin
            busy_d[r] = (busy_q[r] != '0) ? busy_q[r] - LAT_W'(1) : '0;
        end
        if (fire && rd_we_q && (rd_addr_q != '0) && (lat_q != '0) &&
            (busy_d[rd_addr_q] < lat_q)) begin
            busy_d[rd_addr_q] = lat_q;
        end
        busy_d[0] = '0;
    end

    // Scoreboard state; flush leaves it untouched so older producers complete
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                busy_q[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                busy_q[r] <= busy_d[r];
            end
        end
    end

`ifdef ID_OPERAND_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles lost to a scoreboard stall (flushed cycles excluded)
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_id_operand_unit.sv
// Self-checking bench for id_operand_unit: directed scenarios followed by
// randomized traffic, checked each cycle against a ready-time reference model.
module tb_id_operand_unit;
    localparam int XLEN = 32, REG_AW = 5, NRD = 2, NFWD = 3, PAY_W = 64, LAT_W = 2;

    logic                   clk, rst;
    logic                   in_valid, in_allow;
    logic [PAY_W-1:0]       in_payload;
    logic [NRD-1:0]         in_rs_en;
    logic [NRD*REG_AW-1:0]  in_rs_addr;
    logic                   in_rd_we;
    logic [REG_AW-1:0]      in_rd_addr;
    logic [LAT_W-1:0]       in_lat;
    logic                   flush;
    logic [NRD*REG_AW-1:0]  rf_raddr;
    logic [NRD*XLEN-1:0]    rf_rdata;
    logic [NFWD-1:0]        fwd_valid, fwd_we;
    logic [NFWD*REG_AW-1:0] fwd_addr;
    logic [NFWD*XLEN-1:0]   fwd_data;
    logic                   out_valid, out_allow;
    logic [PAY_W-1:0]       out_payload;
    logic [NRD*XLEN-1:0]    out_rs_data;
    logic                   out_rd_we;
    logic [REG_AW-1:0]      out_rd_addr;
    logic [31:0]            stall_cnt;

    id_operand_unit #(.XLEN(XLEN), .REG_AW(REG_AW), .NRD(NRD), .NFWD(NFWD),
                      .PAY_W(PAY_W), .LAT_W(LAT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_allow(in_allow),
        .in_payload(in_payload), .in_rs_en(in_rs_en), .in_rs_addr(in_rs_addr),
        .in_rd_we(in_rd_we), .in_rd_addr(in_rd_addr), .in_lat(in_lat), .flush(flush),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .fwd_valid(fwd_valid), .fwd_we(fwd_we),
        .fwd_addr(fwd_addr), .fwd_data(fwd_data), .out_valid(out_valid),
        .out_allow(out_allow), .out_payload(out_payload), .out_rs_data(out_rs_data),
        .out_rd_we(out_rd_we), .out_rd_addr(out_rd_addr), .stall_cnt(stall_cnt)
    );

    typedef struct packed {
        logic [63:0] pay;
        logic [1:0]  rs_en;
        logic [4:0]  rs0;
        logic [4:0]  rs1;
        logic        rd_we;
        logic [4:0]  rd;
        logic [1:0]  lat;
    } ins_t;

    ins_t offer_q[$];   // instructions presented by stimulus, popped on acceptance
    int   errors = 0;
    int   checks = 0;
    int   fires  = 0;

    // Reference model state
    bit   mon_en = 0;
    bit   acc_flag = 0;
    bit   m_valid = 0;
    ins_t m;
    int   ready[32];    // first cycle in which the register is no longer busy
    int   cyc = 0;
    int   m_scnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic ins_t mk(input logic [63:0] pay, input logic [1:0] en,
                                input logic [4:0] r0, input logic [4:0] r1,
                                input logic we, input logic [4:0] rd, input logic [1:0] lat);
        ins_t x;
        x.pay = pay; x.rs_en = en; x.rs0 = r0; x.rs1 = r1;
        x.rd_we = we; x.rd = rd; x.lat = lat;
        return x;
    endfunction

    // Expected operand: x0 is zero, else youngest matching forward, else RF
    function automatic logic [31:0] ref_op(input logic [4:0] a, input int i);
        if (a == 5'd0) return 32'd0;
        for (int j = 0; j < NFWD; j++)
            if (fwd_valid[j] && fwd_we[j] && fwd_addr[j*REG_AW +: REG_AW] == a)
                return fwd_data[j*XLEN +: XLEN];
        return rf_rdata[i*XLEN +: XLEN];
    endfunction

    function automatic bit reg_busy(input logic [4:0] a);
        return (a != 5'd0) && (ready[a] > cyc);
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m = '0;
        m_scnt = 0;
        acc_flag = 0;
        for (int r = 0; r < 32; r++) ready[r] = 0;
        offer_q.delete();
    endtask

    // Monitor: compare DUT against the model each cycle, pop on acceptance
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            bit m_stall, exp_ov, exp_ia;
            m_stall = m_valid && ((m.rs_en[0] && reg_busy(m.rs0)) ||
                                  (m.rs_en[1] && reg_busy(m.rs1)));
            exp_ov = m_valid && !m_stall && !flush;
            exp_ia = !m_valid || (!m_stall && out_allow);
            check("out_valid", 64'(out_valid), 64'(exp_ov));
            check("in_allow", 64'(in_allow), 64'(exp_ia));
            if (m_valid) check("rf_raddr", 64'(rf_raddr), 64'({m.rs1, m.rs0}));
`ifdef ID_OPERAND_PERF_EN
            check("stall_cnt", 64'(stall_cnt), 64'(m_scnt));
            if (m_stall && !flush) m_scnt++;
`else
            check("stall_cnt", 64'(stall_cnt), 64'(0));
`endif
            if (exp_ov && out_allow) begin
                fires++;
                check("out_payload", out_payload, m.pay);
                check("out_rd_we", 64'(out_rd_we), 64'(m.rd_we));
                check("out_rd_addr", 64'(out_rd_addr), 64'(m.rd));
                check("operand0", 64'(out_rs_data[31:0]), 64'(ref_op(m.rs0, 0)));
                check("operand1", 64'(out_rs_data[63:32]), 64'(ref_op(m.rs1, 1)));
                if (m.rd_we && m.rd != 5'd0 && m.lat != 2'd0 &&
                    ready[m.rd] < cyc + 1 + int'(m.lat))
                    ready[m.rd] = cyc + 1 + int'(m.lat);
            end
            acc_flag = exp_ia && in_valid && !flush;
            if (flush) m_valid = 0;
            else if (exp_ia) m_valid = in_valid;
            if (acc_flag) begin
                if (offer_q.size() == 0) check("offer_queue_empty", 64'(1), 64'(0));
                else m = offer_q.pop_front();
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ins(input ins_t x);
        in_valid   = 1'b1;
        in_payload = x.pay;
        in_rs_en   = x.rs_en;
        in_rs_addr = {x.rs1, x.rs0};
        in_rd_we   = x.rd_we;
        in_rd_addr = x.rd;
        in_lat     = x.lat;
        offer_q.push_back(x);
    endtask

    // Present until accepted; returns in the cycle the instruction is held
    task automatic issue(input ins_t x);
        int n;
        drive_ins(x);
        n = 0;
        do begin
            step();
            n++;
        end while (!acc_flag && n < 40);
        if (!acc_flag) check("issue_timeout", 64'(0), 64'(1));
        in_valid = 1'b0;
    endtask

    // Number of cycles the held instruction waits before out_valid
    task automatic count_stalls(output int n);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 10) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic fwd_idle();
        fwd_valid = '0; fwd_we = '0; fwd_addr = '0; fwd_data = '0;
    endtask

    function automatic ins_t rand_ins();
        return mk({$urandom, $urandom}, 2'($urandom_range(3)),
                  5'($urandom_range(7)), 5'($urandom_range(7)),
                  1'($urandom_range(1)), 5'($urandom_range(7)), 2'($urandom_range(3)));
    endfunction

    initial begin
        int n;
        rst = 1'b1;
        in_valid = 0; in_payload = '0; in_rs_en = '0; in_rs_addr = '0;
        in_rd_we = 0; in_rd_addr = '0; in_lat = '0; flush = 0; out_allow = 1;
        rf_raddr_dummy_init();
        fwd_idle();
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_in_allow", 64'(in_allow), 64'(1));
        check("reset_stall_cnt", 64'(stall_cnt), 64'(0));
        check("reset_payload", out_payload, 64'(0));
        step();
        rst = 1'b0;
        mon_en = 1;

        // Forward priority, held under backpressure
        out_allow = 0;
        issue(mk(64'h1111, 2'b01, 5'd5, 5'd0, 0, 5'd0, 2'd0));
        fwd_valid = 3'b011; fwd_we = 3'b011;
        fwd_addr = {5'd0, 5'd5, 5'd5};
        fwd_data = {32'h0, 32'h0000BBBB, 32'h0000AAAA};
        @(negedge clk);
        check("fwd_prio_port0", 64'(out_rs_data[31:0]), 64'h0000AAAA);
        step();
        fwd_valid = 3'b010;
        @(negedge clk);
        check("fwd_prio_port1", 64'(out_rs_data[31:0]), 64'h0000BBBB);
        step();
        fwd_addr = {5'd6, 5'd6, 5'd6};
        @(negedge clk);
        check("fwd_nomatch_rf", 64'(out_rs_data[31:0]), 64'h11111111);
        step();
        out_allow = 1; fwd_idle();
        step();

        // x0 source ignores a matching forward
        out_allow = 0;
        issue(mk(64'h2222, 2'b01, 5'd0, 5'd0, 0, 5'd0, 2'd0));
        fwd_valid = 3'b001; fwd_we = 3'b001; fwd_addr = '0; fwd_data = {64'h0, 32'h00001234};
        @(negedge clk);
        check("x0_operand", 64'(out_rs_data[31:0]), 64'(0));
        step();
        out_allow = 1; fwd_idle();
        step();

        // Load-use: one stall cycle, then forwarded data
        issue(mk(64'h3333, 2'b00, 5'd0, 5'd0, 1, 5'd7, 2'd1));
        issue(mk(64'h4444, 2'b01, 5'd7, 5'd0, 0, 5'd0, 2'd0));
        fwd_valid = 3'b001; fwd_we = 3'b001; fwd_addr = {10'd0, 5'd7}; fwd_data = {64'h0, 32'h0000CAFE};
        count_stalls(n);
        check("loaduse_stalls", 64'(n), 64'(1));
        check("loaduse_fwd", 64'(out_rs_data[31:0]), 64'h0000CAFE);
`ifdef ID_OPERAND_PERF_EN
        check("loaduse_stall_cnt", 64'(stall_cnt), 64'(1));
`endif
        step();
        fwd_idle();

        // Latency 3 producer, dependent on port 1
        issue(mk(64'h5555, 2'b00, 5'd0, 5'd0, 1, 5'd9, 2'd3));
        issue(mk(64'h6666, 2'b10, 5'd0, 5'd9, 0, 5'd0, 2'd0));
        count_stalls(n);
        check("lat3_stalls", 64'(n), 64'(3));
        step();
        // Re-issue to x9 with lat=1 while its counter is 2
        issue(mk(64'h7777, 2'b00, 5'd0, 5'd0, 1, 5'd9, 2'd3));
        step();
        issue(mk(64'h8888, 2'b00, 5'd0, 5'd0, 1, 5'd9, 2'd1));
        issue(mk(64'h9999, 2'b01, 5'd9, 5'd0, 0, 5'd0, 2'd0));
        count_stalls(n);
        check("max_latency_stalls", 64'(n), 64'(1));
        step();

        // Flush during stall; scoreboard keeps counting down
        issue(mk(64'hAAAA, 2'b00, 5'd0, 5'd0, 1, 5'd10, 2'd3));
        issue(mk(64'hBBBB, 2'b01, 5'd10, 5'd0, 0, 5'd0, 2'd0));
        @(negedge clk);
        check("pre_flush_stalled", 64'(out_valid), 64'(0));
        step();
        flush = 1;
        @(negedge clk);
        check("flush_out_valid", 64'(out_valid), 64'(0));
        step();
        flush = 0;
        issue(mk(64'hCCCC, 2'b01, 5'd10, 5'd0, 0, 5'd0, 2'd0));
        count_stalls(n);
        check("after_flush_stalls", 64'(n), 64'(0));
`ifdef ID_OPERAND_PERF_EN
        check("after_flush_stall_cnt", 64'(stall_cnt), 64'(6));
`endif
        step();

        // Backpressure: held fields stable, release fires immediately
        out_allow = 0;
        issue(mk(64'hDEADBEEF_0BADF00D, 2'b00, 5'd0, 5'd0, 1, 5'd3, 2'd0));
        drive_ins(mk(64'h1234_5678, 2'b00, 5'd0, 5'd0, 0, 5'd0, 2'd0));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_payload", out_payload, 64'hDEADBEEF_0BADF00D);
            check("bp_in_allow", 64'(in_allow), 64'(0));
            step();
        end
        out_allow = 1;
        @(negedge clk);
        check("bp_release_fire", 64'(out_valid), 64'(1));
        step();
        in_valid = 0;
        step();

        // Asynchronous reset in the middle of a stall
        issue(mk(64'hEEEE, 2'b00, 5'd0, 5'd0, 1, 5'd11, 2'd3));
        issue(mk(64'hFFFF, 2'b01, 5'd11, 5'd0, 0, 5'd0, 2'd0));
        @(negedge clk);
        #2;
        mon_en = 0;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'(0));
        check("async_rst_in_allow", 64'(in_allow), 64'(1));
        check("async_rst_stall_cnt", 64'(stall_cnt), 64'(0));
        check("async_rst_rd_addr", 64'(out_rd_addr), 64'(0));
        model_reset();
        step();
        rst = 1'b0;
        mon_en = 1;

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            rf_rdata  = {$urandom, $urandom};
            fwd_valid = 3'($urandom_range(7));
            fwd_we    = 3'($urandom_range(7));
            fwd_addr  = {5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7))};
            fwd_data  = {$urandom, $urandom, $urandom};
            out_allow = ($urandom_range(3) != 0);
            flush     = ($urandom_range(15) == 0);
            if (!in_valid || acc_flag) begin
                if ($urandom_range(3) != 0) drive_ins(rand_ins());
                else in_valid = 1'b0;
            end
            step();
        end
        in_valid = 0; flush = 0; out_allow = 1;
        repeat (10) step();
        check("random_fires_seen", 64'(fires > 100), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    task automatic rf_raddr_dummy_init();
        rf_rdata = {32'h22222222, 32'h11111111};
    endtask

endmodule
